// File: rtl/xadc_pkg.sv
// Shared constants and FSM encoding for the XADC DRP sampler.
//   ADC_W       : width of one XADC conversion result
//   DRP_ADDR_W  : width of the DRP address bus
//   ADDR_VAUX5 / ADDR_VAUX12 : DRP status-register addresses of the aux inputs
//   state_t     : read sequencer states
package xadc_pkg;
    localparam int ADC_W      = 12;
    localparam int DRP_ADDR_W = 7;

    localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX5  = 7'h15;
    localparam logic [DRP_ADDR_W-1:0] ADDR_VAUX12 = 7'h1C;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;
endpackage

// File: rtl/xadc_block_avg.sv
// Block averager: sums 2^AVG_LOG2 captured samples of one channel and
// publishes the truncated mean with a one-cycle strobe.
// Ports:
//   CLK12M, rst   : clock, synchronous active-high reset
//   i_cap         : capture strobe, one value per pulse
//   i_val         : 12-bit conversion result
//   i_chan        : channel the value belongs to
//   o_avg         : last completed block average
//   o_avg_valid   : one-cycle strobe, o_avg updated this cycle
module xadc_block_avg
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic             CLK12M,
    input  logic             rst,
    input  logic             i_cap,
    input  logic [ADC_W-1:0] i_val,
    input  logic             i_chan,
    output logic [ADC_W-1:0] o_avg,
    output logic             o_avg_valid
);
    localparam int AW = ADC_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_blk_ch;
    logic [ADC_W-1:0] r_avg;
    logic             r_avg_valid;

    logic             w_flush;
    logic [AW-1:0]    w_acc_base;
    logic [AW-1:0]    w_acc_n;
    logic [CW-1:0]    w_cnt_base;

    // A sample from the other channel discards the partial block before
    // it is accumulated, so an average never mixes channels.
    assign w_flush    = (i_chan != r_blk_ch);
    assign w_acc_base = w_flush ? '0 : r_acc;
    assign w_cnt_base = w_flush ? '0 : r_cnt;
    assign w_acc_n    = w_acc_base + AW'(i_val);

    always_ff @(posedge CLK12M) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_blk_ch    <= 1'b0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (i_cap) begin
                r_blk_ch <= i_chan;
                if (w_cnt_base == LAST) begin
                    r_avg       <= w_acc_n[AW-1 -: ADC_W];
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_acc_n;
                    r_cnt <= w_cnt_base + 1'b1;
                end
            end
        end
    end

    assign o_avg       = r_avg;
    assign o_avg_valid = r_avg_valid;
endmodule

// File: rtl/xadc_drp_sampler.sv
// XADC DRP read sequencer. Each end-of-conversion launches one DRP read of
// the selected aux channel, waits for drdy (bounded by TIMEOUT_CYC) and
// publishes the 12-bit result plus a block average.
// Ports:
//   CLK12M, rst         : clock, synchronous active-high reset
//   sel                 : 1 = vaux5, 0 = vaux12, sampled at read launch
//   eoc, drdy, do_in    : XADC end-of-conversion, DRP ready, DRP read data
//   den, dwe, di, daddr : DRP request (read-only: dwe/di tied low)
//   sample/sample_valid : last captured conversion and its strobe
//   avg/avg_valid       : last block average and its strobe
//   chan                : channel of sample/avg
//   overrun             : sticky, eoc arrived while a read was in flight
//   timeout_err         : sticky, drdy not seen in time
module xadc_drp_sampler
    import xadc_pkg::*;
#(
    parameter int                    AVG_LOG2    = 3,
    parameter int                    TIMEOUT_CYC = 64,
    parameter logic [DRP_ADDR_W-1:0] ADDR_CH_A   = ADDR_VAUX5,
    parameter logic [DRP_ADDR_W-1:0] ADDR_CH_B   = ADDR_VAUX12
) (
    input  logic                  CLK12M,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  eoc,
    input  logic                  drdy,
    input  logic [15:0]           do_in,
    output logic                  den,
    output logic                  dwe,
    output logic [15:0]           di,
    output logic [DRP_ADDR_W-1:0] daddr,
    output logic [ADC_W-1:0]      sample,
    output logic                  sample_valid,
    output logic [ADC_W-1:0]      avg,
    output logic                  avg_valid,
    output logic                  chan,
    output logic                  overrun,
    output logic                  timeout_err
);
    localparam logic [7:0] T_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                r_state;
    logic                  r_den;
    logic [DRP_ADDR_W-1:0] r_daddr;
    logic                  r_chan_req;
    logic [7:0]            r_timer;
    logic [ADC_W-1:0]      r_sample;
    logic                  r_sample_valid;
    logic                  r_chan;
    logic                  r_overrun;
    logic                  r_timeout;

    logic                  w_cap;
    logic                  w_unused;

    assign w_cap    = (r_state == S_WAIT) && drdy;
    assign w_unused = ^do_in[3:0];

    always_ff @(posedge CLK12M) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_den          <= 1'b0;
            r_daddr        <= ADDR_CH_B;
            r_chan_req     <= 1'b0;
            r_timer        <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_chan         <= 1'b0;
            r_overrun      <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_den          <= 1'b0;
            r_sample_valid <= 1'b0;
            // Any eoc while a read is outstanding is dropped, never chained.
            if (eoc && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (eoc) begin
                        r_chan_req <= sel;
                        r_daddr    <= sel ? ADDR_CH_A : ADDR_CH_B;
                        r_den      <= 1'b1;   // high for the whole REQ cycle
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (drdy) begin
                        r_sample       <= do_in[15:4];
                        r_chan         <= r_chan_req;
                        r_sample_valid <= 1'b1;
                        r_state        <= S_IDLE;
                    end else if (r_timer == T_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    xadc_block_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .CLK12M      (CLK12M),
        .rst         (rst),
        .i_cap       (w_cap),
        .i_val       (do_in[15:4]),
        .i_chan      (r_chan_req),
        .o_avg       (avg),
        .o_avg_valid (avg_valid)
    );

    assign den          = r_den;
    assign dwe          = 1'b0;
    assign di           = '0;
    assign daddr        = r_daddr;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign chan         = r_chan;
    assign overrun      = r_overrun;
    assign timeout_err  = r_timeout;
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed bench for xadc_drp_sampler. Stimulus tasks record, per cycle,
// what each output must show; a negedge process compares every cycle.
module tb_xadc_drp_sampler;
    localparam int AVG_LOG2    = 3;
    localparam int TIMEOUT_CYC = 64;
    localparam int NC          = 2048;
    localparam int F_DADDR = 0, F_SAMPLE = 1, F_AVG = 2, F_CHAN = 3, F_OVR = 4, F_TERR = 5;

    logic        CLK12M = 1'b0;
    logic        rst    = 1'b1;
    logic        sel    = 1'b0;
    logic        eoc    = 1'b0;
    logic        drdy   = 1'b0;
    logic [15:0] do_in  = 16'h0000;

    logic        den, dwe, sample_valid, avg_valid, chan, overrun, timeout_err;
    logic [15:0] di;
    logic [6:0]  daddr;
    logic [11:0] sample, avg;

    xadc_drp_sampler #(
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ADDR_CH_A   (7'h15),
        .ADDR_CH_B   (7'h1C)
    ) dut (
        .CLK12M       (CLK12M),
        .rst          (rst),
        .sel          (sel),
        .eoc          (eoc),
        .drdy         (drdy),
        .do_in        (do_in),
        .den          (den),
        .dwe          (dwe),
        .di           (di),
        .daddr        (daddr),
        .sample       (sample),
        .sample_valid (sample_valid),
        .avg          (avg),
        .avg_valid    (avg_valid),
        .chan         (chan),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 CLK12M = ~CLK12M;

    int cyc = 0;
    always @(posedge CLK12M) cyc <= cyc + 1;

    // Expected output per cycle index.
    bit          e_den [NC];
    bit          e_sv  [NC];
    bit          e_av  [NC];
    logic [6:0]  e_daddr [NC];
    logic [11:0] e_sample[NC];
    logic [11:0] e_avg   [NC];
    bit          e_chan[NC];
    bit          e_ovr [NC];
    bit          e_terr[NC];

    // Current partial averaging block, kept as a plain list of values.
    int blk[$];
    bit blk_ch;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void fill(int t, int f, int v);
        for (int i = t; i < NC; i++) begin
            case (f)
                F_DADDR:  e_daddr[i]  = 7'(v);
                F_SAMPLE: e_sample[i] = 12'(v);
                F_AVG:    e_avg[i]    = 12'(v);
                F_CHAN:   e_chan[i]   = (v != 0);
                F_OVR:    e_ovr[i]    = (v != 0);
                default:  e_terr[i]   = (v != 0);
            endcase
        end
    endfunction

    function automatic void model_reset(int t);
        fill(t, F_DADDR, 'h1C);
        fill(t, F_SAMPLE, 0);
        fill(t, F_AVG, 0);
        fill(t, F_CHAN, 0);
        fill(t, F_OVR, 0);
        fill(t, F_TERR, 0);
        for (int i = t; i < NC; i++) begin
            e_den[i] = 1'b0;
            e_sv[i]  = 1'b0;
            e_av[i]  = 1'b0;
        end
        blk.delete();
        blk_ch = 1'b0;
    endfunction

    // drdy seen at cycle k: results appear at k+1.
    function automatic void capture(int k, int v, bit ch);
        int sum;
        fill(k + 1, F_SAMPLE, v);
        fill(k + 1, F_CHAN, ch);
        e_sv[k + 1] = 1'b1;
        if (ch != blk_ch) blk.delete();
        blk_ch = ch;
        blk.push_back(v);
        if (blk.size() == (1 << AVG_LOG2)) begin
            sum = 0;
            foreach (blk[j]) sum += blk[j];
            fill(k + 1, F_AVG, sum / (1 << AVG_LOG2));
            e_av[k + 1] = 1'b1;
            blk.delete();
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK12M);
            #1;
        end
    endtask

    // One read: eoc now, den next cycle, drdy dly cycles after den (dly>=1).
    // ov_off>0 raises an extra eoc that many cycles after the first one.
    task automatic do_read(input bit s, input int dly, input logic [15:0] d, input int ov_off);
        int c, k;
        c = cyc;
        k = c + 1 + dly;
        eoc = 1'b1;
        sel = s;
        e_den[c + 1] = 1'b1;
        fill(c + 1, F_DADDR, s ? 'h15 : 'h1C);
        step(1);
        sel = ~s;
        for (int i = c + 1; i <= k; i++) begin
            eoc   = (ov_off > 0) && (i == c + ov_off);
            drdy  = (i == k);
            do_in = (i == k) ? d : ~d;
            if (eoc) fill(i + 1, F_OVR, 1);
            if (i == k) capture(k, int'(d[15:4]), s);
            step(1);
        end
        eoc  = 1'b0;
        drdy = 1'b0;
    endtask

    always @(negedge CLK12M) begin
        if (chk_en && cyc < NC) begin
            chk("den",          den,          e_den[cyc]);
            chk("dwe",          dwe,          0);
            chk("di",           di,           0);
            chk("daddr",        daddr,        e_daddr[cyc]);
            chk("sample",       sample,       e_sample[cyc]);
            chk("sample_valid", sample_valid, e_sv[cyc]);
            chk("avg",          avg,          e_avg[cyc]);
            chk("avg_valid",    avg_valid,    e_av[cyc]);
            chk("chan",         chan,         e_chan[cyc]);
            chk("overrun",      overrun,      e_ovr[cyc]);
            chk("timeout_err",  timeout_err,  e_terr[cyc]);
        end
    end

    initial begin
        int c;
        model_reset(0);
        step(3);
        rst = 1'b0;
        chk_en = 1'b1;
        step(2);

        // 1: single vaux5 read, drdy 3 cycles after den
        do_read(1'b1, 3, 16'hABC0, 0);
        chk("t1_sample", sample, 12'hABC);
        chk("t1_chan",   chan,   1);
        chk("t1_daddr",  daddr,  7'h15);
        step(2);

        // 2: eight vaux12 reads 0x100..0x107 -> avg 0x103
        for (int i = 0; i < 8; i++) do_read(1'b0, 1 + (i % 3), 16'(('h100 + i) << 4), 0);
        chk("t2_avg",   avg,   12'h103);
        chk("t2_daddr", daddr, 7'h1C);
        step(2);

        // 3: partial vaux12 block, then eight vaux5 reads of 0x800
        for (int i = 0; i < 4; i++) do_read(1'b0, 2, 16'h3FF0, 0);
        for (int i = 0; i < 8; i++) do_read(1'b1, 2, 16'h8000, 0);
        chk("t3_avg",  avg,  12'h800);
        chk("t3_chan", chan, 1);
        step(2);

        // 4: drdy withheld -> timeout 64 cycles after WAIT entry
        c = cyc;
        eoc = 1'b1;
        sel = 1'b0;
        e_den[c + 1] = 1'b1;
        fill(c + 1, F_DADDR, 'h1C);
        fill(c + 2 + TIMEOUT_CYC, F_TERR, 1);
        step(1);
        eoc = 1'b0;
        step(TIMEOUT_CYC + 2);
        chk("t4_terr", timeout_err, 1);
        do_read(1'b1, 2, 16'h1230, 0);
        chk("t4_next_sample", sample, 12'h123);

        // 5: second eoc during WAIT, drdy 10 cycles after den
        do_read(1'b0, 10, 16'h4560, 4);
        chk("t5_ovr",    overrun, 1);
        chk("t5_sample", sample,  12'h456);
        step(2);

        // 6: reset during WAIT, late drdy ignored
        c = cyc;
        eoc = 1'b1;
        sel = 1'b1;
        e_den[c + 1] = 1'b1;
        fill(c + 1, F_DADDR, 'h15);
        step(1);
        eoc = 1'b0;
        step(2);
        rst = 1'b1;
        model_reset(cyc + 1);
        step(1);
        rst = 1'b0;
        step(2);
        drdy = 1'b1;
        do_in = 16'hFFF0;
        step(1);
        drdy = 1'b0;
        step(3);
        chk("t6_sample", sample,      12'h000);
        chk("t6_ovr",    overrun,     0);
        chk("t6_terr",   timeout_err, 0);
        chk("t6_daddr",  daddr,       7'h1C);

        // 7: eoc coincident with drdy counts as overrun, not chained
        do_read(1'b0, 2, 16'h5550, 3);
        chk("t7_ovr",    overrun, 1);
        chk("t7_sample", sample,  12'h555);
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/xadc_drp_sampler.md
Name: xadc_drp_sampler

Overview:
- Sequencer between the XADC wrapper and the bin2bcd/fnd4digit display path.
- On each XADC end-of-conversion, issues one DRP read of the selected aux channel (vaux5 or vaux12) and captures the 12-bit result.
- Produces a per-sample value and a block average over 2^AVG_LOG2 samples, each with a one-cycle valid strobe.
- Replaces free-running den=eoc wiring and slow-clock sampling of do_out with a proper drdy handshake, timeout and overrun detection.

Parameters:
- AVG_LOG2, 3: log2 of samples per average; 0..6 legal; 0 means avg equals sample.
- TIMEOUT_CYC, 64: CLK12M cycles to wait for drdy after den before aborting; 2..255.
- ADDR_CH_A, 7'h15: DRP address used when sel=1 (vaux5).
- ADDR_CH_B, 7'h1C: DRP address used when sel=0 (vaux12).

Ports:
- CLK12M  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  channel select: 1 = vaux5, 0 = vaux12; sampled only when a read is launched.
- eoc  in  1  XADC end-of-conversion pulse.
- drdy  in  1  XADC DRP data ready.
- do_in  in  16  XADC DRP read data; result in bits [15:4].
- den  out  1  DRP enable; one-cycle pulse.
- dwe  out  1  DRP write enable; constant 0.
- di  out  16  DRP write data; constant 0.
- daddr  out  7  DRP address.
- sample  out  12  last captured conversion.
- sample_valid  out  1  one-cycle strobe; sample updated this cycle.
- avg  out  12  last completed block average.
- avg_valid  out  1  one-cycle strobe; avg updated this cycle.
- chan  out  1  sel value associated with sample/avg.
- overrun  out  1  sticky; eoc arrived while a read was in flight.
- timeout_err  out  1  sticky; drdy not seen within TIMEOUT_CYC.

Behaviour:
- Reset values: den=0, daddr=ADDR_CH_B, sample=0, avg=0, sample_valid=0, avg_valid=0, chan=0, overrun=0, timeout_err=0. Accumulator, count and timer are all 0; state is IDLE. Reset mid-read abandons the read; a later drdy in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE, eoc=1: latch sel into chan_req; daddr <= (sel ? ADDR_CH_A : ADDR_CH_B); go to REQ.
- REQ: den=1 for exactly this cycle; timer cleared; go to WAIT. daddr holds until the next launch.
- WAIT, drdy=1:
  - sample <= do_in[15:4]; chan <= chan_req; sample_valid=1 on the following cycle (registered); go to IDLE.
  - Latency: eoc at cycle 0, den at cycle 1, drdy at cycle k gives sample_valid at cycle k+1.
- WAIT, no drdy: timer increments. When timer = TIMEOUT_CYC-1 without drdy: timeout_err <= 1, sample unchanged, no strobe, go to IDLE.
- eoc in REQ or WAIT: eoc dropped, overrun <= 1. eoc coincident with drdy in WAIT is also an overrun; a new read is not chained.
- drdy outside WAIT: ignored.
- Averaging (on each capture):
  - acc width = 12+AVG_LOG2 bits, no overflow possible.
  - If chan_req differs from the channel of the current partial block, clear acc and cnt first; the partial block is discarded.
  - Then acc_n = acc + do_in[15:4] and cnt_n = cnt + 1.
  - If cnt = 2^AVG_LOG2-1: avg <= acc_n[11+AVG_LOG2:AVG_LOG2] (truncating), avg_valid=1 on the same cycle as sample_valid, acc <= 0, cnt <= 0.
  - With AVG_LOG2=0, every sample also strobes avg, and avg equals sample.
- Sticky flags clear only on rst.

Decomposition:
- Package xadc_pkg:
  - ADC_W=12 and DRP_ADDR_W=7.
  - Channel address constants 7'h15 and 7'h1C.
  - FSM state encoding (IDLE=0, REQ=1, WAIT=2).
- Sub-module xadc_block_avg:
  - Contains the accumulator, count, channel-change flush and the avg/avg_valid registers.
  - Inputs: CLK12M, rst, capture strobe, 12-bit value, channel bit.
- The top module holds the FSM, timer, DRP outputs and flags.

Test Plan:
- Reset then one eoc with sel=1 and drdy 3 cycles after den, do_in=16'hABC0: den pulses once at cycle 1 with daddr=7'h15; sample=12'hABC with sample_valid one cycle; chan=1; avg_valid stays 0.
- AVG_LOG2=3, sel=0, 8 reads returning 12'h100..12'h107 in bits [15:4]: daddr=7'h1C; avg=12'h103 (sum 0x81C>>3) with avg_valid on the 8th sample_valid cycle only.
- 4 reads on sel=0, then sel=1 for 8 reads of 12'h800: the first partial block is discarded; the first avg_valid comes after 8 ch-A samples with avg=12'h800 and chan=1.
- eoc, then drdy withheld with TIMEOUT_CYC=64: timeout_err rises exactly 64 cycles after the WAIT entry; no sample_valid; the next eoc starts a normal read.
- Second eoc during WAIT, drdy 10 cycles after den: overrun=1, only one den pulse, one sample_valid.
- rst asserted in WAIT, drdy arriving after rst release: drdy ignored; all outputs at reset values; no strobes.
